// File: rtl/ctrl_defs.sv
// Shared definitions for the control pipeline: control-bundle bit positions,
// forwarding-select encodings, default widths and the narrowing helpers that
// produce the later-stage control views.
package ctrl_defs;

  localparam int REG_AW    = 5;
  localparam int ALUCTRL_W = 4;
  localparam int CTRL_W    = ALUCTRL_W + 6;

  // id_ctrl = {RegWrite, ALUSrc, MemWrite, MemToReg, Branch, MemRead, ALUControl}
  localparam int CB_REGWRITE = ALUCTRL_W + 5;
  localparam int CB_ALUSRC   = ALUCTRL_W + 4;
  localparam int CB_MEMWRITE = ALUCTRL_W + 3;
  localparam int CB_MEMTOREG = ALUCTRL_W + 2;
  localparam int CB_BRANCH   = ALUCTRL_W + 1;
  localparam int CB_MEMREAD  = ALUCTRL_W;
  localparam int CB_ALU_LSB  = 0;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // EX/MEM keeps only what memory access and write-back still need.
  function automatic logic [3:0] mem_view(input logic [CTRL_W-1:0] c);
    return {c[CB_REGWRITE], c[CB_MEMWRITE], c[CB_MEMTOREG], c[CB_MEMREAD]};
  endfunction

  // MEM/WB keeps only the write-back controls.
  function automatic logic [1:0] wb_view(input logic [3:0] m);
    return {m[3], m[1]};
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Purely combinational hazard detection: load-use stall, branch flush of
// IF/ID and the EX operand forwarding selects.
module hazard_fwd_unit
  import ctrl_defs::*;
#(
  parameter int AW = 5
) (
  input  logic          ex_valid_i,
  input  logic          ex_memread_i,
  input  logic [AW-1:0] ex_rd_i,
  input  logic [AW-1:0] ex_rs1_i,
  input  logic [AW-1:0] ex_rs2_i,
  input  logic          id_valid_i,
  input  logic [AW-1:0] id_rs1_i,
  input  logic [AW-1:0] id_rs2_i,
  input  logic          id_uses_rs2_i,
  input  logic          ex_br_taken_i,
  input  logic          mem_valid_i,
  input  logic          mem_regwrite_i,
  input  logic [AW-1:0] mem_rd_i,
  input  logic          wb_valid_i,
  input  logic          wb_regwrite_i,
  input  logic [AW-1:0] wb_rd_i,
  output logic          load_use_o,
  output logic          stall_o,
  output logic          flush_ifid_o,
  output logic [1:0]    fwd_a_o,
  output logic [1:0]    fwd_b_o
);

  logic mem_fwd_ok;
  logic wb_fwd_ok;

  // Load-use detection; a taken branch squashes the dependent instruction,
  // so the flush takes priority over the stall.
  always_comb begin
    load_use_o   = ex_valid_i && ex_memread_i && (ex_rd_i != '0) && id_valid_i &&
                   ((ex_rd_i == id_rs1_i) || (id_uses_rs2_i && (ex_rd_i == id_rs2_i)));
    stall_o      = load_use_o && !ex_br_taken_i;
    flush_ifid_o = ex_br_taken_i;
  end

  // Forwarding selects; the younger EX/MEM result beats MEM/WB, x0 never forwards.
  always_comb begin
    mem_fwd_ok = mem_valid_i && mem_regwrite_i && (mem_rd_i != '0);
    wb_fwd_ok  = wb_valid_i && wb_regwrite_i && (wb_rd_i != '0);

    fwd_a_o = FWD_RF;
    if (mem_fwd_ok && (mem_rd_i == ex_rs1_i))     fwd_a_o = FWD_EXMEM;
    else if (wb_fwd_ok && (wb_rd_i == ex_rs1_i))  fwd_a_o = FWD_MEMWB;

    fwd_b_o = FWD_RF;
    if (mem_fwd_ok && (mem_rd_i == ex_rs2_i))     fwd_b_o = FWD_EXMEM;
    else if (wb_fwd_ok && (wb_rd_i == ex_rs2_i))  fwd_b_o = FWD_MEMWB;
  end

endmodule

// File: rtl/ctrl_pipeline.sv
// Carries the ID-stage control bundle and register indices through the
// ID/EX, EX/MEM and MEM/WB registers and reports hazard status back to the
// front end. A bubble is valid=0 with every ctrl, rd and rs field zero.
module ctrl_pipeline
  import ctrl_defs::*;
#(
  parameter int REG_AW    = 5,
  parameter int ALUCTRL_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [ALUCTRL_W+5:0]   id_ctrl,
  input  logic [REG_AW-1:0]      id_rs1,
  input  logic [REG_AW-1:0]      id_rs2,
  input  logic                   id_uses_rs2,
  input  logic [REG_AW-1:0]      id_rd,
  input  logic                   ex_br_taken,
  output logic                   stall,
  output logic                   flush_ifid,
  output logic                   ex_valid,
  output logic [ALUCTRL_W+5:0]   ex_ctrl,
  output logic [REG_AW-1:0]      ex_rd,
  output logic                   mem_valid,
  output logic [3:0]             mem_ctrl,
  output logic [REG_AW-1:0]      mem_rd,
  output logic                   wb_valid,
  output logic [1:0]             wb_ctrl,
  output logic [REG_AW-1:0]      wb_rd,
  output logic [1:0]             fwd_a,
  output logic [1:0]             fwd_b
);

  localparam int CW = ALUCTRL_W + 6;

  logic              ex_valid_q,  ex_valid_d;
  logic [CW-1:0]     ex_ctrl_q,   ex_ctrl_d;
  logic [REG_AW-1:0] ex_rd_q,     ex_rd_d;
  logic [REG_AW-1:0] ex_rs1_q,    ex_rs1_d;
  logic [REG_AW-1:0] ex_rs2_q,    ex_rs2_d;
  logic              mem_valid_q, mem_valid_d;
  logic [3:0]        mem_ctrl_q,  mem_ctrl_d;
  logic [REG_AW-1:0] mem_rd_q,    mem_rd_d;
  logic              wb_valid_q,  wb_valid_d;
  logic [1:0]        wb_ctrl_q,   wb_ctrl_d;
  logic [REG_AW-1:0] wb_rd_q,     wb_rd_d;

  logic              load_use;

  hazard_fwd_unit #(
    .AW(REG_AW)
  ) u_hazard (
    .ex_valid_i     (ex_valid_q),
    .ex_memread_i   (ex_ctrl_q[ALUCTRL_W]),
    .ex_rd_i        (ex_rd_q),
    .ex_rs1_i       (ex_rs1_q),
    .ex_rs2_i       (ex_rs2_q),
    .id_valid_i     (id_valid),
    .id_rs1_i       (id_rs1),
    .id_rs2_i       (id_rs2),
    .id_uses_rs2_i  (id_uses_rs2),
    .ex_br_taken_i  (ex_br_taken),
    .mem_valid_i    (mem_valid_q),
    .mem_regwrite_i (mem_ctrl_q[3]),
    .mem_rd_i       (mem_rd_q),
    .wb_valid_i     (wb_valid_q),
    .wb_regwrite_i  (wb_ctrl_q[1]),
    .wb_rd_i        (wb_rd_q),
    .load_use_o     (load_use),
    .stall_o        (stall),
    .flush_ifid_o   (flush_ifid),
    .fwd_a_o        (fwd_a),
    .fwd_b_o        (fwd_b)
  );

  // Next-state for all three stages: ID/EX takes a bubble on stall, flush or
  // an empty ID slot; EX/MEM and MEM/WB advance every cycle.
  always_comb begin
    ex_valid_d = 1'b0;
    ex_ctrl_d  = '0;
    ex_rd_d    = '0;
    ex_rs1_d   = '0;
    ex_rs2_d   = '0;
    if (id_valid && !load_use && !ex_br_taken) begin
      ex_valid_d = 1'b1;
      ex_ctrl_d  = id_ctrl;
      ex_rd_d    = id_rd;
      ex_rs1_d   = id_rs1;
      ex_rs2_d   = id_rs2;
    end

    mem_valid_d = ex_valid_q;
    mem_ctrl_d  = ex_valid_q ? mem_view(ex_ctrl_q) : 4'b0000;
    mem_rd_d    = ex_rd_q;

    wb_valid_d  = mem_valid_q;
    wb_ctrl_d   = mem_valid_q ? wb_view(mem_ctrl_q) : 2'b00;
    wb_rd_d     = mem_rd_q;
  end

  // Stage registers with synchronous reset to an empty pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_ctrl_q   <= '0;
      ex_rd_q     <= '0;
      ex_rs1_q    <= '0;
      ex_rs2_q    <= '0;
      mem_valid_q <= 1'b0;
      mem_ctrl_q  <= '0;
      mem_rd_q    <= '0;
      wb_valid_q  <= 1'b0;
      wb_ctrl_q   <= '0;
      wb_rd_q     <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_ctrl_q   <= ex_ctrl_d;
      ex_rd_q     <= ex_rd_d;
      ex_rs1_q    <= ex_rs1_d;
      ex_rs2_q    <= ex_rs2_d;
      mem_valid_q <= mem_valid_d;
      mem_ctrl_q  <= mem_ctrl_d;
      mem_rd_q    <= mem_rd_d;
      wb_valid_q  <= wb_valid_d;
      wb_ctrl_q   <= wb_ctrl_d;
      wb_rd_q     <= wb_rd_d;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign ex_ctrl   = ex_ctrl_q;
  assign ex_rd     = ex_rd_q;
  assign mem_valid = mem_valid_q;
  assign mem_ctrl  = mem_ctrl_q;
  assign mem_rd    = mem_rd_q;
  assign wb_valid  = wb_valid_q;
  assign wb_ctrl   = wb_ctrl_q;
  assign wb_rd     = wb_rd_q;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Bench for ctrl_pipeline: a driver issues one ID bundle per cycle and pushes
// the expected full output snapshot for that cycle into a queue; a monitor on
// the falling edge pops and compares. The reference tracks which instruction
// occupies each stage and derives the outputs from the hazard rules directly.
module tb_ctrl_pipeline;

  localparam int W = 40;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [9:0] id_ctrl = '0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_uses_rs2 = 1'b0;
  logic       ex_br_taken = 1'b0;

  logic       stall, flush_ifid, ex_valid, mem_valid, wb_valid;
  logic [9:0] ex_ctrl;
  logic [3:0] mem_ctrl;
  logic [1:0] wb_ctrl, fwd_a, fwd_b;
  logic [4:0] ex_rd, mem_rd, wb_rd;

  ctrl_pipeline dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_ctrl     (id_ctrl),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs2 (id_uses_rs2),
    .id_rd       (id_rd),
    .ex_br_taken (ex_br_taken),
    .stall       (stall),
    .flush_ifid  (flush_ifid),
    .ex_valid    (ex_valid),
    .ex_ctrl     (ex_ctrl),
    .ex_rd       (ex_rd),
    .mem_valid   (mem_valid),
    .mem_ctrl    (mem_ctrl),
    .mem_rd      (mem_rd),
    .wb_valid    (wb_valid),
    .wb_ctrl     (wb_ctrl),
    .wb_rd       (wb_rd),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b)
  );

  // ---------------- reference model ----------------
  // One record per instruction; an all-zero record is an empty slot.
  typedef struct packed {
    bit       v;
    bit [9:0] c;
    bit [4:0] rd;
    bit [4:0] rs1;
    bit [4:0] rs2;
  } instr_t;

  instr_t m_ex = '0, m_mem = '0, m_wb = '0;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Bundle bits: 9 RegWrite, 8 ALUSrc, 7 MemWrite, 6 MemToReg, 5 Branch, 4 MemRead
  function automatic logic [1:0] ref_fwd(input bit [4:0] src);
    if (m_mem.v && m_mem.c[9] && m_mem.rd != 0 && m_mem.rd == src) return 2'b10;
    if (m_wb.v && m_wb.c[9] && m_wb.rd != 0 && m_wb.rd == src) return 2'b01;
    return 2'b00;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit r, input bit v, input bit [9:0] c,
                      input bit [4:0] rs1, input bit [4:0] rs2, input bit u,
                      input bit [4:0] rd, input bit br, input bit chk);
    bit lu;
    instr_t nxt;
    logic [W-1:0] e;
    @(posedge clk);
    #1;
    rst = r; id_valid = v; id_ctrl = c; id_rs1 = rs1; id_rs2 = rs2;
    id_uses_rs2 = u; id_rd = rd; ex_br_taken = br;

    lu = m_ex.v && m_ex.c[4] && m_ex.rd != 0 && v &&
         (m_ex.rd == rs1 || (u && m_ex.rd == rs2));
    e = {lu && !br, br,
         m_ex.v, m_ex.c, m_ex.rd,
         m_mem.v, m_mem.c[9], m_mem.c[7], m_mem.c[6], m_mem.c[4], m_mem.rd,
         m_wb.v, m_wb.c[9], m_wb.c[6], m_wb.rd,
         ref_fwd(m_ex.rs1), ref_fwd(m_ex.rs2)};
    if (chk) exp_q.push_back(e);

    // What the coming clock edge does to the pipe.
    if (r) begin
      m_ex = '0; m_mem = '0; m_wb = '0;
    end else begin
      nxt = '0;
      if (v && !lu && !br) nxt = '{v: 1'b1, c: c, rd: rd, rs1: rs1, rs2: rs2};
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = nxt;
    end
  endtask

  task automatic bubble();
    step(0, 0, 10'h000, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic rand_step(input bit r);
    step(r, 1'($urandom_range(0, 1)), 10'($urandom), 5'($urandom_range(0, 7)),
         5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
         $urandom_range(0, 9) == 0, 1);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] got, e;
    if (exp_q.size() > 0) begin
      got = {stall, flush_ifid, ex_valid, ex_ctrl, ex_rd, mem_valid, mem_ctrl, mem_rd,
             wb_valid, wb_ctrl, wb_rd, fwd_a, fwd_b};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL snapshot #%0d at %0t: got=%h exp=%h", n_cmp, $time, got, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset with random ID inputs; first cycle has unknown pre-reset state.
    step(1, 1'($urandom), 10'($urandom), 5'($urandom), 5'($urandom), 1, 5'($urandom), 0, 0);
    repeat (2) step(1, 1'($urandom), 10'($urandom), 5'($urandom), 5'($urandom), 1, 5'($urandom), 0, 1);

    // Latency of one bundle through ex/mem/wb.
    step(0, 1, 10'h2A0, 0, 0, 0, 5'd3, 0, 1);
    repeat (3) bubble();

    // Load-use on rs1, then rs2 without uses_rs2.
    step(0, 1, 10'h350, 1, 2, 0, 5'd5, 0, 1);
    step(0, 1, 10'h200, 5, 1, 1, 5'd6, 0, 1);
    step(0, 1, 10'h200, 5, 1, 1, 5'd6, 0, 1);
    step(0, 1, 10'h350, 1, 2, 0, 5'd5, 0, 1);
    step(0, 1, 10'h200, 1, 5, 0, 5'd6, 0, 1);
    repeat (3) bubble();

    // Branch flush, then flush and load-use together.
    step(0, 1, 10'h020, 1, 2, 1, 5'd0, 0, 1);
    step(0, 1, 10'h200, 3, 4, 1, 5'd8, 1, 1);
    bubble();
    step(0, 1, 10'h350, 1, 2, 0, 5'd5, 0, 1);
    step(0, 1, 10'h200, 5, 5, 1, 5'd9, 1, 1);
    repeat (3) bubble();

    // Forwarding priority: both write x7, then MEM stage not writing, then x0.
    step(0, 1, 10'h200, 0, 0, 0, 5'd7, 0, 1);
    step(0, 1, 10'h200, 0, 0, 0, 5'd7, 0, 1);
    step(0, 1, 10'h200, 7, 7, 1, 5'd1, 0, 1);
    bubble();
    step(0, 1, 10'h200, 0, 0, 0, 5'd7, 0, 1);
    step(0, 1, 10'h000, 0, 0, 0, 5'd7, 0, 1);
    step(0, 1, 10'h200, 7, 2, 1, 5'd1, 0, 1);
    bubble();
    step(0, 1, 10'h200, 0, 0, 0, 5'd0, 0, 1);
    step(0, 1, 10'h200, 0, 0, 0, 5'd0, 0, 1);
    step(0, 1, 10'h200, 0, 0, 1, 5'd1, 0, 1);
    repeat (3) bubble();

    // Reset mid-stream with three instructions in flight.
    step(0, 1, 10'h350, 1, 2, 1, 5'd4, 0, 1);
    step(0, 1, 10'h200, 3, 3, 1, 5'd5, 0, 1);
    step(0, 1, 10'h200, 6, 6, 1, 5'd6, 0, 1);
    step(1, 1, 10'h200, 4, 4, 1, 5'd7, 0, 1);
    bubble();
    bubble();

    // Random traffic over a small register set to provoke hazards.
    for (int i = 0; i < 400; i++) rand_step($urandom_range(0, 49) == 0);
    repeat (3) bubble();

    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d snapshots left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
